// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 bus bundle between a single master and the on-chip SRAM slave.
// The master drives the request fields, and the slave returns the response fields.
interface wb_sram_slave_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;

    modport master (
        output adr, dat_w, sel, we, stb, cyc, cti, bte,
        input  dat_r, ack, err, rty, stall
    );

    modport slave (
        input  adr, dat_w, sel, we, stb, cyc, cti, bte,
        output dat_r, ack, err, rty, stall
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone B4 SRAM slave with one outstanding transfer at a time and programmable wait states.
// Every beat goes IDLE -> (WAIT x WAIT_STATES) -> RESP, so bursts need no cti/bte handling.
module wb_sram_slave #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic           clk_i,
    input  logic           rst_i,
    wb_sram_slave_if.slave wb,
    output logic           busy_o
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [2:0]  CNT_INIT  = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem [MEM_WORDS];

    logic [31:0]   off_p0;
    logic          hit_p0;
    logic [AW-1:0] idx_p0;
    logic          accept_p0;

    logic [AW-1:0] idx_p1;
    logic [31:0]   dat_p1;
    logic [3:0]    sel_p1;
    logic          we_p1;
    logic          hit_p1;
    logic [31:0]   rdat_p1;
    logic [AW-1:0] rd_idx;
    logic          resp;
    logic          unused_bits;

    // Stage 0: decode the incoming request
    assign off_p0    = wb.adr - BASE_ADDR;
    assign hit_p0    = (wb.adr >= BASE_ADDR) && ({1'b0, off_p0} < MEM_BYTES);
    assign idx_p0    = off_p0[AW+1:2];
    assign accept_p0 = (state_q == S_IDLE) && wb.cyc && wb.stb;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_p0) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // Dropping cyc while waiting abandons the transfer silently.
                if (!wb.cyc)            state_d = S_IDLE;
                else if (cnt_q == 3'd0) state_d = S_RESP;
                else                    cnt_d   = cnt_q - 3'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage 1: latched request, array access
    assign rd_idx = (state_q == S_IDLE) ? idx_p0 : idx_p1;

    always_ff @(posedge clk_i) begin
        if (accept_p0) begin
            idx_p1 <= idx_p0;
            dat_p1 <= wb.dat_w;
            sel_p1 <= wb.sel;
            we_p1  <= wb.we;
            hit_p1 <= hit_p0;
        end
        rdat_p1 <= mem[rd_idx];
        if (state_q == S_RESP && we_p1 && hit_p1 && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_p1[i]) mem[idx_p1][8*i +: 8] <= dat_p1[8*i +: 8];
            end
        end
    end

    // Stage 2: response, suppressed in the cycle a reset lands
    assign resp     = (state_q == S_RESP) && !rst_i;
    assign wb.ack   = resp && hit_p1;
    assign wb.err   = resp && !hit_p1;
    assign wb.rty   = 1'b0;
    assign wb.stall = (state_q == S_WAIT);
    assign wb.dat_r = (resp && hit_p1 && !we_p1) ? rdat_p1 : 32'd0;
    assign busy_o   = (state_q != S_IDLE);

    assign unused_bits = ^{wb.cti, wb.bte, off_p0[1:0], off_p0[31:AW+2]};

endmodule
